// File: rtl/cache_pkg.sv
// Shared types and helpers for the tag-only cache level and its replacement unit.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILL,
    WTHRU,
    RESP
  } state_e;

  localparam logic WP_WT   = 1'b0;  // write-through, no write-allocate
  localparam logic WP_WB   = 1'b1;  // write-back, write-allocate
  localparam logic RP_FIFO = 1'b0;
  localparam logic RP_LRU  = 1'b1;

  // Way-select width; a direct-mapped cache still carries a 1-bit way field.
  function automatic int way_w(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

endpackage

// File: rtl/cache_level_if.sv
// Request/response handshake toward the upper level plus the request port
// toward the lower level. The cache sits on the slave modport.
interface cache_level_if #(
  parameter int ADDR_W = 48
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              resp_valid;
  logic              resp_hit;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;

  modport master (
    output req_valid, req_addr, req_write, mem_ready,
    input  req_ready, resp_valid, resp_hit, mem_valid, mem_addr, mem_write
  );

  modport slave (
    input  req_valid, req_addr, req_write, mem_ready,
    output req_ready, resp_valid, resp_hit, mem_valid, mem_addr, mem_write
  );
endinterface

// File: rtl/cache_repl.sv
// Replacement state: per-set FIFO pointer and per-way LRU ages. Both are kept
// up to date regardless of the active policy; the policy only picks which one
// names the victim.
module cache_repl import cache_pkg::*; #(
  parameter  int NUM_SETS = 64,
  parameter  int ASSOC    = 4,
  localparam int INDEX_W  = $clog2(NUM_SETS),
  localparam int WAY_W    = way_w(ASSOC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] set_idx,
  input  logic [WAY_W-1:0]   way,
  input  logic               touch,
  input  logic               fill,
  input  logic               policy,
  output logic [WAY_W-1:0]   victim
);

  logic [WAY_W-1:0] ptr_q [NUM_SETS];
  logic [WAY_W-1:0] ptr_d [NUM_SETS];
  logic [WAY_W-1:0] age_q [NUM_SETS][ASSOC];
  logic [WAY_W-1:0] age_d [NUM_SETS][ASSOC];
  logic [WAY_W-1:0] ref_age;
  logic [WAY_W-1:0] victim_lru;

  // Next replacement state. A fill treats the incoming way as the oldest, so
  // every other way ages; this turns the all-zero reset state into a strict
  // age ordering once the set has been filled.
  always_comb begin
    ptr_d   = ptr_q;
    age_d   = age_q;
    ref_age = age_q[set_idx][way];
    if (fill) begin
      ref_age = WAY_W'(ASSOC - 1);
      ptr_d[set_idx] = (ptr_q[set_idx] == WAY_W'(ASSOC - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
    end
    if (touch || fill) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (WAY_W'(w) != way && age_q[set_idx][w] < ref_age) begin
          age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
        end
      end
      age_d[set_idx][way] = '0;
    end
  end

  // Victim for the indexed set: lowest way holding the oldest age under LRU.
  always_comb begin
    victim_lru = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (age_q[set_idx][w] == WAY_W'(ASSOC - 1)) victim_lru = WAY_W'(w);
    end
    if (ASSOC == 1)          victim = '0;
    else if (policy == RP_LRU) victim = victim_lru;
    else                     victim = ptr_q[set_idx];
  end

  // Replacement state registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '{default: '0};
      age_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/cache_level.sv
// Tag-only set-associative cache level: one request at a time, tag lookup,
// victim selection, dirty tracking, lower-level write-back/fill/write-through
// traffic and saturating statistics counters.
module cache_level import cache_pkg::*; #(
  parameter int ADDR_W      = 48,
  parameter int NUM_SETS    = 64,
  parameter int ASSOC       = 4,
  parameter int BLOCK_BYTES = 32,
  parameter int CNT_W       = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_policy,
  input  logic             replace_policy,
  cache_level_if.slave     bus,
  output logic [CNT_W-1:0] reads,
  output logic [CNT_W-1:0] writes,
  output logic [CNT_W-1:0] read_misses,
  output logic [CNT_W-1:0] write_misses,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] writebacks
);

  localparam int OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
  localparam int WAY_W    = way_w(ASSOC);
  localparam int BLK_W    = ADDR_W - OFFSET_W;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               write_q, write_d, wp_q, wp_d, rp_q, rp_d, hit_q, hit_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic               req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d, mem_valid_q, mem_valid_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   reads_q, reads_d, writes_q, writes_d, rmiss_q, rmiss_d;
  logic [CNT_W-1:0]   wmiss_q, wmiss_d, hits_q, hits_d, wbs_q, wbs_d;
  logic [TAG_W-1:0]   tag_q [NUM_SETS][ASSOC];
  logic [TAG_W-1:0]   tag_d [NUM_SETS][ASSOC];
  logic               valid_q [NUM_SETS][ASSOC];
  logic               valid_d [NUM_SETS][ASSOC];
  logic               dirty_q [NUM_SETS][ASSOC];
  logic               dirty_d [NUM_SETS][ASSOC];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [ADDR_W-1:0]  blk_addr;
  logic               lk_hit, inv_found;
  logic [WAY_W-1:0]   lk_way, inv_way, repl_victim, victim_way, repl_way;
  logic               repl_touch, repl_fill;
  logic               unused_offset;

  // Offset bits never affect a tag-only cache.
  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

  assign idx      = blk_q[INDEX_W-1:0];
  assign tag      = blk_q[BLK_W-1 -: TAG_W];
  assign blk_addr = {blk_q, {OFFSET_W{1'b0}}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Parallel tag compare and lowest-index invalid way for the latched set.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : repl_victim;
  end

  cache_repl #(
    .NUM_SETS (NUM_SETS),
    .ASSOC    (ASSOC)
  ) u_repl (
    .clk     (clk),
    .reset   (reset),
    .set_idx (idx),
    .way     (repl_way),
    .touch   (repl_touch),
    .fill    (repl_fill),
    .policy  (rp_q),
    .victim  (repl_victim)
  );

  // Controller next state, registered outputs, counters and array updates.
  always_comb begin
    state_d = state_q;  blk_d = blk_q;  write_d = write_q;  wp_d = wp_q;  rp_d = rp_q;
    hit_d = hit_q;  way_d = way_q;
    req_ready_d = req_ready_q;  resp_valid_d = resp_valid_q;  resp_hit_d = resp_hit_q;
    mem_valid_d = mem_valid_q;  mem_addr_d = mem_addr_q;  mem_write_d = mem_write_q;
    reads_d = reads_q;  writes_d = writes_q;  rmiss_d = rmiss_q;
    wmiss_d = wmiss_q;  hits_d = hits_q;  wbs_d = wbs_q;
    tag_d = tag_q;  valid_d = valid_q;  dirty_d = dirty_q;
    repl_touch = 1'b0;  repl_fill = 1'b0;  repl_way = way_q;
    case (state_q)
      IDLE: if (bus.req_valid && req_ready_q) begin
        blk_d       = bus.req_addr[ADDR_W-1:OFFSET_W];
        write_d     = bus.req_write;
        wp_d        = write_policy;
        rp_d        = replace_policy;
        req_ready_d = 1'b0;
        state_d     = LOOKUP;
      end
      LOOKUP: begin
        hit_d = lk_hit;
        if (write_q) writes_d = sat_inc(writes_q);
        else         reads_d  = sat_inc(reads_q);
        if (lk_hit)       hits_d  = sat_inc(hits_q);
        else if (write_q) wmiss_d = sat_inc(wmiss_q);
        else              rmiss_d = sat_inc(rmiss_q);
        if (lk_hit) begin
          repl_touch = 1'b1;
          repl_way   = lk_way;
          way_d      = lk_way;
          if (write_q && wp_q == WP_WB) dirty_d[idx][lk_way] = 1'b1;
        end else begin
          way_d = victim_way;
        end
        if (write_q && wp_q == WP_WT) begin
          state_d = WTHRU;  mem_valid_d = 1'b1;  mem_write_d = 1'b1;  mem_addr_d = blk_addr;
        end else if (lk_hit) begin
          state_d = RESP;  resp_valid_d = 1'b1;  resp_hit_d = 1'b1;
        end else if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
          state_d = WBACK;  mem_valid_d = 1'b1;  mem_write_d = 1'b1;
          mem_addr_d = {tag_q[idx][victim_way], idx, {OFFSET_W{1'b0}}};
        end else begin
          state_d = FILL;  mem_valid_d = 1'b1;  mem_write_d = 1'b0;  mem_addr_d = blk_addr;
        end
      end
      // mem_valid drops for one cycle between the write-back and the fill.
      WBACK: if (bus.mem_ready) begin
        wbs_d       = sat_inc(wbs_q);
        mem_valid_d = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = blk_addr;
        state_d     = FILL;
      end
      FILL: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
        end else if (bus.mem_ready) begin
          tag_d[idx][way_q]   = tag;
          valid_d[idx][way_q] = 1'b1;
          dirty_d[idx][way_q] = write_q && wp_q == WP_WB;
          repl_fill    = 1'b1;
          mem_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WTHRU: if (bus.mem_ready) begin
        mem_valid_d  = 1'b0;
        resp_valid_d = 1'b1;
        resp_hit_d   = hit_q;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state resets; the latched request and tag array do not need to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;  hit_q <= 1'b0;
      req_ready_q <= 1'b1;  resp_valid_q <= 1'b0;  resp_hit_q <= 1'b0;
      mem_valid_q <= 1'b0;  mem_addr_q <= '0;  mem_write_q <= 1'b0;
      reads_q <= '0;  writes_q <= '0;  rmiss_q <= '0;
      wmiss_q <= '0;  hits_q <= '0;  wbs_q <= '0;
      valid_q <= '{default: 1'b0};
      dirty_q <= '{default: 1'b0};
    end else begin
      state_q <= state_d;  hit_q <= hit_d;
      req_ready_q <= req_ready_d;  resp_valid_q <= resp_valid_d;  resp_hit_q <= resp_hit_d;
      mem_valid_q <= mem_valid_d;  mem_addr_q <= mem_addr_d;  mem_write_q <= mem_write_d;
      reads_q <= reads_d;  writes_q <= writes_d;  rmiss_q <= rmiss_d;
      wmiss_q <= wmiss_d;  hits_q <= hits_d;  wbs_q <= wbs_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    blk_q   <= blk_d;
    write_q <= write_d;
    wp_q    <= wp_d;
    rp_q    <= rp_d;
    way_q   <= way_d;
    tag_q   <= tag_d;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_write  = mem_write_q;
  assign reads          = reads_q;
  assign writes         = writes_q;
  assign read_misses    = rmiss_q;
  assign write_misses   = wmiss_q;
  assign hits           = hits_q;
  assign writebacks     = wbs_q;

endmodule

// File: tb/tb_cache_level.sv
// Directed bench for cache_level: 4 sets, 2 ways, 16-byte blocks, 2-bit
// counters so saturation is reachable.
module tb_cache_level;
  localparam int AW = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_policy = 1'b1;
  logic       replace_policy = 1'b1;
  logic [1:0] reads, writes, read_misses, write_misses, hits, writebacks;

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] log_addr[$];
  logic          log_wr[$];

  cache_level_if #(.ADDR_W(AW)) bus ();

  cache_level #(
    .ADDR_W(AW), .NUM_SETS(4), .ASSOC(2), .BLOCK_BYTES(16), .CNT_W(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .write_policy   (write_policy),
    .replace_policy (replace_policy),
    .bus            (bus),
    .reads          (reads),
    .writes         (writes),
    .read_misses    (read_misses),
    .write_misses   (write_misses),
    .hits           (hits),
    .writebacks     (writebacks)
  );

  always #5 clk = ~clk;

  // Record every accepted lower-level transaction.
  always @(posedge clk) begin
    if (reset && bus.mem_valid && bus.mem_ready) begin
      log_addr.push_back(bus.mem_addr);
      log_wr.push_back(bus.mem_write);
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_log();
  endtask

  // One request; lat counts negedges after the accepting edge until resp_valid.
  task automatic do_req(input string tag, input logic [AW-1:0] a, input logic w,
                        output logic hit, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    hit = 1'b0;
    while (!bus.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (bus.resp_valid) hit = bus.resp_hit;
    else chk_val({tag, " resp timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    int   l;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    chk_val("rst req_ready", bus.req_ready, 1);
    chk_val("rst resp_valid", bus.resp_valid, 0);
    chk_val("rst mem_valid", bus.mem_valid, 0);
    chk_val("rst mem_addr", bus.mem_addr, 0);
    chk_val("rst mem_write", bus.mem_write, 0);
    chk_val("rst reads", reads, 0);
    chk_val("rst hits", hits, 0);

    // Read miss then read hit in the same block
    do_req("t1a", 16'h000, 1'b0, h, l);
    chk_val("t1 miss hit", h, 0);
    chk_val("t1 miss lat", l, 3);
    chk_val("t1 fill n", log_addr.size(), 1);
    chk_val("t1 fill addr", log_addr[0], 16'h000);
    chk_val("t1 fill wr", log_wr[0], 0);
    do_req("t1b", 16'h004, 1'b0, h, l);
    chk_val("t1 hit hit", h, 1);
    chk_val("t1 hit lat", l, 2);
    chk_val("t1 no new traffic", log_addr.size(), 1);
    chk_val("t1 reads", reads, 2);
    chk_val("t1 read_misses", read_misses, 1);
    chk_val("t1 hits", hits, 1);

    // Write-back, LRU
    do_reset();
    write_policy = 1'b1;
    replace_policy = 1'b1;
    do_req("t2a", 16'h000, 1'b1, h, l);
    do_req("t2b", 16'h040, 1'b0, h, l);
    do_req("t2c", 16'h000, 1'b0, h, l);
    chk_val("t2 reread hit", h, 1);
    clear_log();
    do_req("t2d", 16'h080, 1'b0, h, l);
    chk_val("t2 080 hit", h, 0);
    chk_val("t2 080 n", log_addr.size(), 1);
    chk_val("t2 080 addr", log_addr[0], 16'h080);
    chk_val("t2 080 wr", log_wr[0], 0);
    clear_log();
    do_req("t2e", 16'h040, 1'b0, h, l);
    chk_val("t2 040 hit", h, 0);
    chk_val("t2 040 n", log_addr.size(), 2);
    chk_val("t2 wb addr", log_addr[0], 16'h000);
    chk_val("t2 wb wr", log_wr[0], 1);
    chk_val("t2 fill addr", log_addr[1], 16'h040);
    chk_val("t2 fill wr", log_wr[1], 0);
    chk_val("t2 writebacks", writebacks, 1);
    do_req("t2f", 16'h080, 1'b0, h, l);
    chk_val("t2 080 kept", h, 1);
    chk_val("t2 reads sat", reads, 3);
    chk_val("t2 read_misses", read_misses, 3);
    chk_val("t2 write_misses", write_misses, 1);

    // Write-back, FIFO
    do_reset();
    replace_policy = 1'b0;
    do_req("t3a", 16'h000, 1'b1, h, l);
    do_req("t3b", 16'h040, 1'b0, h, l);
    do_req("t3c", 16'h000, 1'b0, h, l);
    chk_val("t3 reread hit", h, 1);
    clear_log();
    do_req("t3d", 16'h080, 1'b0, h, l);
    chk_val("t3 080 hit", h, 0);
    chk_val("t3 n", log_addr.size(), 2);
    chk_val("t3 wb addr", log_addr[0], 16'h000);
    chk_val("t3 wb wr", log_wr[0], 1);
    chk_val("t3 fill addr", log_addr[1], 16'h080);
    do_req("t3e", 16'h040, 1'b0, h, l);
    chk_val("t3 040 kept", h, 1);
    chk_val("t3 writebacks", writebacks, 1);

    // Write-through, no-write-allocate
    do_reset();
    write_policy = 1'b0;
    replace_policy = 1'b1;
    do_req("t4a", 16'h100, 1'b1, h, l);
    chk_val("t4 wmiss hit", h, 0);
    chk_val("t4 wmiss lat", l, 3);
    chk_val("t4 wmiss n", log_addr.size(), 1);
    chk_val("t4 wmiss addr", log_addr[0], 16'h100);
    chk_val("t4 wmiss wr", log_wr[0], 1);
    chk_val("t4 write_misses", write_misses, 1);
    clear_log();
    do_req("t4b", 16'h100, 1'b0, h, l);
    chk_val("t4 read no-alloc", h, 0);
    chk_val("t4 read fill wr", log_wr[0], 0);
    clear_log();
    do_req("t4c", 16'h100, 1'b1, h, l);
    chk_val("t4 whit hit", h, 1);
    chk_val("t4 whit n", log_addr.size(), 1);
    chk_val("t4 whit addr", log_addr[0], 16'h100);
    chk_val("t4 whit wr", log_wr[0], 1);
    clear_log();
    do_req("t4d", 16'h140, 1'b0, h, l);
    do_req("t4e", 16'h180, 1'b0, h, l);
    chk_val("t4 evict n", log_addr.size(), 2);
    chk_val("t4 evict wr0", log_wr[0], 0);
    chk_val("t4 evict addr1", log_addr[1], 16'h180);
    chk_val("t4 evict wr1", log_wr[1], 0);
    chk_val("t4 writebacks", writebacks, 0);
    do_req("t4f", 16'h100, 1'b0, h, l);
    chk_val("t4 100 evicted", h, 0);

    // Lower-level stall during FILL
    do_reset();
    write_policy = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h200;
    bus.req_write = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_val("t5 mem_write", bus.mem_write, 0);
    for (int i = 0; i < 5; i++) begin
      chk_val("t5 stall mem_valid", bus.mem_valid, 1);
      chk_val("t5 stall mem_addr", bus.mem_addr, 16'h200);
      chk_val("t5 stall req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    chk_val("t5 no early resp", bus.resp_valid, 0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk_val("t5 resp_valid", bus.resp_valid, 1);
    chk_val("t5 resp_hit", bus.resp_hit, 0);
    chk_val("t5 mem_valid drop", bus.mem_valid, 0);
    chk_val("t5 one fill", log_addr.size(), 1);

    // Counter saturation
    do_reset();
    do_req("t6a", 16'h300, 1'b0, h, l);
    for (int i = 0; i < 5; i++) begin
      do_req("t6h", 16'h300, 1'b0, h, l);
      chk_val("t6 rehit", h, 1);
    end
    chk_val("t6 hits sat", hits, 3);
    chk_val("t6 reads sat", reads, 3);
    chk_val("t6 read_misses", read_misses, 1);

    // Reset during WBACK
    do_reset();
    do_req("t7a", 16'h000, 1'b1, h, l);
    do_req("t7b", 16'h040, 1'b0, h, l);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h080;
    bus.req_write = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_val("t7 wback valid", bus.mem_valid, 1);
    chk_val("t7 wback write", bus.mem_write, 1);
    chk_val("t7 wback addr", bus.mem_addr, 16'h000);
    reset = 1'b0;
    @(negedge clk);
    chk_val("t7 mem_valid", bus.mem_valid, 0);
    chk_val("t7 mem_addr", bus.mem_addr, 0);
    chk_val("t7 req_ready", bus.req_ready, 1);
    chk_val("t7 resp_valid", bus.resp_valid, 0);
    chk_val("t7 reads", reads, 0);
    chk_val("t7 writes", writes, 0);
    chk_val("t7 read_misses", read_misses, 0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    do_req("t7c", 16'h040, 1'b0, h, l);
    chk_val("t7 040 now misses", h, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
